// File: rtl/toggle_rx_pkg.sv
// Shared types and default sizing for the two-phase toggle receiver.
package toggle_rx_pkg;

  typedef enum logic {RX_IDLE, RX_PENDING} rx_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/toggle_rx_if.sv
// Producer toggle handshake plus downstream valid/ready drain port of toggle_rx.
interface toggle_rx_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  logic [DATA_W-1:0]          shared;
  logic                       get_it;
  logic                       ack;
  logic [DATA_W-1:0]          out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;

  modport slave (
    input  shared, get_it, out_ready,
    output ack, out_data, out_valid, count, overflow
  );

  modport master (
    output shared, get_it, out_ready,
    input  ack, out_data, out_valid, count, overflow
  );
endinterface

// File: rtl/toggle_rx_fifo.sv
// Show-ahead FIFO: out_data always presents the entry at the read pointer.
module toggle_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          in_data,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_eff;
  logic              push_eff;

  // Pop on empty is dropped; a push into a full buffer is only taken alongside a pop.
  assign pop_eff  = pop && (count != '0);
  assign push_eff = push && ((count < CW'(DEPTH)) || pop_eff);
  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/toggle_rx.sv
// Two-phase toggle receiver: edge detect on get_it, buffer shared, toggle ack.
// Optional build macro TOGGLE_RX_SYNC_EN adds a 2-flop synchroniser on get_it.
module toggle_rx
  import toggle_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic         clk,
  input logic         reset_n,
  toggle_rx_if.slave  bus
);
  localparam int CW = $clog2(DEPTH+1);

  rx_state_e     state;
  rx_state_e     state_d;
  logic          get_it_s;
  logic          get_it_q;
  logic          evt;
  logic          pop;
  logic          space;
  logic          push;
  logic          ack_q;
  logic          ack_tgl;
  logic          ovf_q;
  logic          ovf_set;
  logic [CW-1:0] count;

`ifdef TOGGLE_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], bus.get_it};
  end

  assign get_it_s = sync_q[1];
`else
  assign get_it_s = bus.get_it;
`endif

  assign evt   = get_it_s ^ get_it_q;
  assign pop   = bus.out_valid && bus.out_ready;
  assign space = (count < CW'(DEPTH)) || pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RX_IDLE;
      get_it_q <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_d;
      get_it_q <= get_it_s;
      if (ack_tgl) ack_q <= ~ack_q;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // A second event while a byte is still waiting for space is merged and flagged.
  always_comb begin
    state_d = state;
    push    = 1'b0;
    ack_tgl = 1'b0;
    ovf_set = 1'b0;
    case (state)
      RX_IDLE: begin
        if (evt) begin
          if (space) begin
            push    = 1'b1;
            ack_tgl = 1'b1;
          end else begin
            state_d = RX_PENDING;
          end
        end
      end
      RX_PENDING: begin
        if (evt) ovf_set = 1'b1;
        if (space) begin
          push    = 1'b1;
          ack_tgl = 1'b1;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  toggle_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .in_data  (bus.shared),
    .out_data (bus.out_data),
    .count    (count)
  );

  assign bus.count     = count;
  assign bus.out_valid = (count != '0);
  assign bus.ack       = ack_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_rx.sv
// Directed bench for toggle_rx with a queue-based behavioural model checked every cycle.
module tb_toggle_rx;
  import toggle_rx_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);
`ifdef TOGGLE_RX_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  toggle_rx_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus_if ();

  toggle_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue, a "byte waiting for room" flag, an accepted-byte counter.
  logic [DATA_W-1:0] q[$];
  bit                m_wait;
  bit                m_ovf;
  int                m_acks;
  bit                m_prev;
  bit                g_d1, g_d2;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_wait = 0; m_ovf = 0; m_acks = 0; m_prev = 0; g_d1 = 0; g_d2 = 0;
    end else begin
      bit seen, ev, do_pop, room;
`ifdef TOGGLE_RX_SYNC_EN
      seen = g_d2; g_d2 = g_d1; g_d1 = bus_if.get_it;
`else
      seen = bus_if.get_it;
`endif
      ev     = seen ^ m_prev;
      m_prev = seen;
      do_pop = (q.size() > 0) && bus_if.out_ready;
      room   = (q.size() < DEPTH) || do_pop;
      if (do_pop) void'(q.pop_front());
      if (m_wait && ev) m_ovf = 1;
      if (m_wait || ev) begin
        if (room) begin
          q.push_back(bus_if.shared);
          m_acks++;
          m_wait = 0;
        end else begin
          m_wait = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ack", {31'd0, bus_if.ack}, {31'd0, m_acks[0]});
    check("count", 32'(bus_if.count), 32'(q.size()));
    check("out_valid", {31'd0, bus_if.out_valid}, {31'd0, q.size() > 0});
    check("overflow", {31'd0, bus_if.overflow}, {31'd0, m_ovf});
    check("pending", {31'd0, dut.state == RX_PENDING}, {31'd0, m_wait});
    if (q.size() > 0) check("out_data", 32'(bus_if.out_data), 32'(q[0]));
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] v, input int wait_cycles);
    bus_if.shared = v;
    bus_if.get_it = ~bus_if.get_it;
    tick(wait_cycles);
  endtask

  initial begin
    int n;
    logic a0;
    bus_if.shared = '0;
    bus_if.get_it = 1'b0;
    bus_if.out_ready = 1'b0;
    tick(2);
    check("rst_ack", {31'd0, bus_if.ack}, 32'd0);
    check("rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_count", 32'(bus_if.count), 32'd0);
    check("rst_data", 32'(bus_if.out_data), 32'd0);
    check("rst_ovf", {31'd0, bus_if.overflow}, 32'd0);
    reset_n = 1'b1;
    tick(1);

    // 1: three bytes streamed straight through
    bus_if.out_ready = 1'b1;
    send(8'd1, SL + 1);
    @(negedge clk);
    check("t1_valid", {31'd0, bus_if.out_valid}, 32'd1);
    check("t1_data", 32'(bus_if.out_data), 32'd1);
    tick(1);
    send(8'd2, 3);
    send(8'd3, 3);
    check("t1_ack", {31'd0, bus_if.ack}, 32'd1);
    check("t1_count", 32'(bus_if.count), 32'd0);
    check("t1_ovf", {31'd0, bus_if.overflow}, 32'd0);

    // 2: fill, then a fifth byte waits for room
    bus_if.out_ready = 1'b0;
    for (int v = 10; v <= 13; v++) send(DATA_W'(v), 2 + SL);
    check("t2_full", 32'(bus_if.count), 32'd4);
    check("t2_ack4", {31'd0, bus_if.ack}, 32'd1);
    send(8'd14, 1 + SL);
    check("t2_pend", {31'd0, dut.state == RX_PENDING}, 32'd1);
    check("t2_ack_hold", {31'd0, bus_if.ack}, 32'd1);
    bus_if.out_ready = 1'b1;
    tick(1);
    bus_if.out_ready = 1'b0;
    check("t2_count", 32'(bus_if.count), 32'd4);
    check("t2_ack", {31'd0, bus_if.ack}, 32'd0);
    check("t2_head", 32'(bus_if.out_data), 32'd11);

    // 3: extra event while waiting sets the sticky overflow
    send(8'd20, 1 + SL);
    send(8'd20, 1 + SL);
    check("t3_ovf", {31'd0, bus_if.overflow}, 32'd1);
    check("t3_ack", {31'd0, bus_if.ack}, 32'd0);
    bus_if.out_ready = 1'b1;
    tick(8);
    bus_if.out_ready = 1'b0;
    check("t3_drained", 32'(bus_if.count), 32'd0);
    check("t3_one_ack", {31'd0, bus_if.ack}, 32'd1);
    check("t3_ovf_sticky", {31'd0, bus_if.overflow}, 32'd1);

    // 4: push and pop on the same edge while full
    for (int v = 30; v <= 33; v++) send(DATA_W'(v), 2 + SL);
    send(8'd34, SL);
    bus_if.out_ready = 1'b1;
    tick(1);
    bus_if.out_ready = 1'b0;
    check("t4_count", 32'(bus_if.count), 32'd4);
    check("t4_head", 32'(bus_if.out_data), 32'd31);
    check("t4_ack", {31'd0, bus_if.ack}, 32'd0);
    bus_if.out_ready = 1'b1;
    tick(6);
    bus_if.out_ready = 1'b0;
    check("t4_empty", 32'(bus_if.count), 32'd0);

    // 5: asynchronous reset mid-stream, with two bytes and then with a waiting byte
    send(8'd40, 2 + SL);
    send(8'd41, 2 + SL);
    check("t5_count2", 32'(bus_if.count), 32'd2);
    #1 reset_n = 1'b0;
    bus_if.get_it = 1'b0;
    #1;
    check("t5_rst_count", 32'(bus_if.count), 32'd0);
    check("t5_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("t5_rst_data", 32'(bus_if.out_data), 32'd0);
    check("t5_rst_ack", {31'd0, bus_if.ack}, 32'd0);
    check("t5_rst_ovf", {31'd0, bus_if.overflow}, 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(3);
    check("t5_no_ack", {31'd0, bus_if.ack}, 32'd0);
    for (int v = 50; v <= 53; v++) send(DATA_W'(v), 2 + SL);
    send(8'd54, 1 + SL);
    check("t5_pend", {31'd0, dut.state == RX_PENDING}, 32'd1);
    #1 reset_n = 1'b0;
    bus_if.get_it = 1'b0;
    #1;
    check("t5_rst2_count", 32'(bus_if.count), 32'd0);
    check("t5_rst2_pend", {31'd0, dut.state == RX_PENDING}, 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(3);
    check("t5_no_ack2", {31'd0, bus_if.ack}, 32'd0);
    check("t5_empty2", {31'd0, bus_if.out_valid}, 32'd0);

    // 6: toggle-to-ack latency in edges
    a0 = bus_if.ack;
    bus_if.shared = 8'd60;
    bus_if.get_it = ~bus_if.get_it;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus_if.ack != a0) break;
    end
    check("t6_latency", 32'(n), 32'(1 + SL));
    check("t6_data", 32'(bus_if.out_data), 32'd60);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
